dm_mc: RTL and testbench



---
 rtl/dm_mc_pkg.sv | 26 ++
 rtl/dm_lane_merge.sv | 63 ++++++
 rtl/dm_mc.sv | 129 ++++++++++++
 tb/tb_dm_mc.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_mc_pkg.sv
// rtl/dm_mc_pkg.sv - dm_mc shared types: request-type codes, FSM states, lane slice helpers
package dm_mc_pkg;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b010;
    localparam logic [2:0] DM_HU = 3'b011;
    localparam logic [2:0] DM_B  = 3'b100;
    localparam logic [2:0] DM_BU = 3'b101;
    localparam logic [2:0] DM_L  = 3'b110;
    localparam logic [2:0] DM_R  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } dm_state_e;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] b);
        return w[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [15:0] half_sel(input logic [31:0] w, input logic b1);
        return b1 ? w[31:16] : w[15:0];
    endfunction

endpackage

// File: rtl/dm_lane_merge.sv
// rtl/dm_lane_merge.sv - combinational byte-lane merge for dm_mc loads and stores
module dm_lane_merge
    import dm_mc_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wd,
    input  logic [2:0]  req_type,
    input  logic [1:0]  b,
    output logic [31:0] st_word,
    output logic [31:0] ld_data,
    output logic        err
);

    logic [4:0]  sh_lo;
    logic [4:0]  sh_hi;
    logic [31:0] mask;
    logic [31:0] ins;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        // sh_lo = 8*b, sh_hi = 8*(3-b); 3-b of a 2-bit value is just ~b
        sh_lo   = {b, 3'b000};
        sh_hi   = {~b, 3'b000};
        bsel    = byte_sel(old_word, b);
        hsel    = half_sel(old_word, b[1]);
        err     = 1'b0;
        mask    = 32'h0;
        ins     = 32'h0;
        ld_data = old_word;
        case (req_type)
            DM_H, DM_HU: begin
                err     = b[0];
                mask    = b[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                ins     = {wd[15:0], wd[15:0]};
                ld_data = {{16{hsel[15] & (req_type == DM_H)}}, hsel};
            end
            DM_B, DM_BU: begin
                mask    = 32'h0000_00FF << sh_lo;
                ins     = {4{wd[7:0]}};
                ld_data = {{24{bsel[7] & (req_type == DM_B)}}, bsel};
            end
            DM_L: begin
                mask    = 32'hFFFF_FFFF >> sh_hi;
                ins     = wd >> sh_hi;
                ld_data = (old_word << sh_hi) | (wd & ~(32'hFFFF_FFFF << sh_hi));
            end
            DM_R: begin
                mask    = 32'hFFFF_FFFF << sh_lo;
                ins     = wd << sh_lo;
                ld_data = (old_word >> sh_lo) | (wd & ~(32'hFFFF_FFFF >> sh_lo));
            end
            default: begin
                err     = (b != 2'b00);
                mask    = 32'hFFFF_FFFF;
                ins     = wd;
                ld_data = old_word;
            end
        endcase
        st_word = (old_word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/dm_mc.sv
// rtl/dm_mc.sv - multi-cycle MEM-stage data memory with wait states; store trace under DM_MC_TRACE_EN
module dm_mc
    import dm_mc_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wd,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rd,
    output logic        resp_err
);

    localparam int         DEPTH = 1 << (ADDR_W - 2);
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    dm_state_e   state;
    dm_state_e   state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;

    logic        q_we;
    logic [2:0]  q_type;
    logic [31:0] q_addr;
    logic [31:0] q_wd;
    logic [31:0] q_pc;

    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    logic [31:0] old_word;
    logic [31:0] st_word;
    logic [31:0] ld_data;
    logic        m_err;
    logic [31:0] cur_rd;
    logic [31:0] rd_hold;
    logic        access;

    assign req_ready = (state == ST_IDLE);
    assign access    = (state == ST_ACCESS) && !reset;
    assign old_word  = mem[q_addr[ADDR_W-1:2]];
    assign cur_rd    = (q_we || m_err) ? 32'h0 : ld_data;

    // rd is live during the response pulse and then held from rd_hold
    assign resp_valid = access;
    assign resp_err   = access && m_err;
    assign resp_rd    = access ? cur_rd : rd_hold;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_nx   = LAT4;
                    state_nx = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rd_hold <= 32'h0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (access) begin
                rd_hold <= cur_rd;
            end
        end
    end

    // Request fields only matter after an accept, so they carry no reset
    always_ff @(posedge clk) begin
        if (req_ready && req_valid) begin
            q_we   <= req_we;
            q_type <= req_type;
            q_addr <= req_addr;
            q_wd   <= req_wd;
            q_pc   <= req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (access && q_we && !m_err) begin
            mem[q_addr[ADDR_W-1:2]] <= st_word;
        end
    end

`ifdef DM_MC_TRACE_EN
    always_ff @(posedge clk) begin
        if (access && q_we && !m_err) begin
            $display("%d@%h: *%h <= %h", $time, q_pc, {q_addr[31:2], 2'b00}, st_word);
        end
    end
`else
    logic unused_trace;
    assign unused_trace = ^{q_pc, q_addr[31:ADDR_W]};
`endif

    dm_lane_merge u_lane_merge (
        .old_word (old_word),
        .wd       (q_wd),
        .req_type (q_type),
        .b        (q_addr[1:0]),
        .st_word  (st_word),
        .ld_data  (ld_data),
        .err      (m_err)
    );

endmodule

// File: tb/tb_dm_mc.sv
// tb/tb_dm_mc.sv - self-checking bench for dm_mc (LATENCY=2 and LATENCY=0 instances)
module tb_dm_mc;

    localparam logic [2:0] T_W  = 3'b000;
    localparam logic [2:0] T_H  = 3'b010;
    localparam logic [2:0] T_HU = 3'b011;
    localparam logic [2:0] T_B  = 3'b100;
    localparam logic [2:0] T_BU = 3'b101;
    localparam logic [2:0] T_L  = 3'b110;
    localparam logic [2:0] T_R  = 3'b111;

    logic clk = 1'b0;
    logic reset;

    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_err;
    logic [2:0]  a_req_type;
    logic [31:0] a_req_addr, a_req_wd, a_req_pc, a_resp_rd;
    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_err;
    logic [2:0]  b_req_type;
    logic [31:0] b_req_addr, b_req_wd, b_req_pc, b_resp_rd;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] bm [2][4096];

    always #5 clk = ~clk;

    dm_mc #(.ADDR_W(12), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_type(a_req_type), .req_addr(a_req_addr), .req_wd(a_req_wd), .req_pc(a_req_pc),
        .resp_valid(a_resp_valid), .resp_rd(a_resp_rd), .resp_err(a_resp_err)
    );

    dm_mc #(.ADDR_W(12), .LATENCY(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_type(b_req_type), .req_addr(b_req_addr), .req_wd(b_req_wd), .req_pc(b_req_pc),
        .resp_valid(b_resp_valid), .resp_rd(b_resp_rd), .resp_err(b_resp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic g_ready(input int sel);
        return (sel != 0) ? b_req_ready : a_req_ready;
    endfunction
    function automatic logic g_valid(input int sel);
        return (sel != 0) ? b_resp_valid : a_resp_valid;
    endfunction
    function automatic logic g_err(input int sel);
        return (sel != 0) ? b_resp_err : a_resp_err;
    endfunction
    function automatic logic [31:0] g_rd(input int sel);
        return (sel != 0) ? b_resp_rd : a_resp_rd;
    endfunction

    task automatic drive(input int sel, input logic v, input logic we, input logic [2:0] ty,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            a_req_valid = v; a_req_we = we; a_req_type = ty;
            a_req_addr = addr; a_req_wd = wd; a_req_pc = $urandom;
        end else begin
            b_req_valid = v; b_req_we = we; b_req_type = ty;
            b_req_addr = addr; b_req_wd = wd; b_req_pc = $urandom;
        end
    endtask

    // Byte-addressed reference: little-endian memory of 4096 bytes per instance
    task automatic model_access(input int sel, input logic we, input logic [2:0] ty,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
        int base, b;
        logic [31:0] m, t;
        logic [15:0] h;
        logic [7:0]  by;
        base = int'(addr[11:0]) & ~3;
        b    = int'(addr[1:0]);
        m    = {bm[sel][base+3], bm[sel][base+2], bm[sel][base+1], bm[sel][base]};
        err  = ((ty == T_W) && b != 0) || ((ty == T_H || ty == T_HU) && (b % 2) == 1);
        rd   = 32'h0;
        if (err) return;
        h  = 16'(m >> (8 * b));
        by = 8'(m >> (8 * b));
        if (!we) begin
            case (ty)
                T_W:  rd = m;
                T_H:  rd = {{16{h[15]}}, h};
                T_HU: rd = {16'h0, h};
                T_B:  rd = {{24{by[7]}}, by};
                T_BU: rd = {24'h0, by};
                T_L:  rd = (m << (8 * (3 - b))) | (wd & ((32'd1 << (8 * (3 - b))) - 32'd1));
                T_R:  rd = (m >> (8 * b)) | (wd & ~(32'hFFFF_FFFF >> (8 * b)));
                default: rd = m;
            endcase
        end else begin
            case (ty)
                T_W:       for (int i = 0; i < 4; i++) bm[sel][base+i] = 8'(wd >> (8 * i));
                T_H, T_HU: for (int i = 0; i < 2; i++) bm[sel][base+b+i] = 8'(wd >> (8 * i));
                T_B, T_BU: bm[sel][base+b] = wd[7:0];
                T_L: begin
                    t = wd >> (8 * (3 - b));
                    for (int i = 0; i <= b; i++) bm[sel][base+i] = 8'(t >> (8 * i));
                end
                T_R: begin
                    t = wd << (8 * b);
                    for (int i = b; i < 4; i++) bm[sel][base+i] = 8'(t >> (8 * i));
                end
                default: ;
            endcase
        end
    endtask

    // Called and returns at a negedge; checks latency, busy window, data, error and hold
    task automatic txn(input int sel, input logic we, input logic [2:0] ty, input logic [31:0] addr,
                       input logic [31:0] wd, input string tag,
                       output logic [31:0] got_rd, output logic got_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n, lat;
        bit          seen, busy_bad;
        lat = (sel != 0) ? 0 : 2;
        model_access(sel, we, ty, addr, wd, exp_rd, exp_err);
        check({tag, "_ready"}, 32'(g_ready(sel)), 32'd1);
        drive(sel, 1'b1, we, ty, addr, wd);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        n = 0; seen = 0; busy_bad = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (g_ready(sel)) busy_bad = 1;
            if (g_valid(sel)) seen = 1;
        end
        got_rd  = g_rd(sel);
        got_err = g_err(sel);
        check({tag, "_latency"}, n, lat + 1);
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        check({tag, "_rd"}, got_rd, exp_rd);
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_after"}, {29'h0, g_valid(sel), g_ready(sel), g_err(sel)}, 32'b010);
        check({tag, "_hold"}, g_rd(sel), exp_rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [7:0]  pattern;
        logic [2:0]  tys [7];
        tys = '{T_W, T_H, T_HU, T_B, T_BU, T_L, T_R};
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 4096; i++) bm[s][i] = 8'h0;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(a_req_ready), 32'd1);
        check("rst_valid", 32'(a_resp_valid), 32'd0);
        check("rst_rd", a_resp_rd, 32'h0);
        check("rst_err", 32'(a_resp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        txn(0, 1, T_W, 32'h10, 32'h12345678, "p1_sw", rd, er);
        txn(0, 0, T_W, 32'h10, 32'h0, "p1_lw", rd, er);
        check("p1_lw_const", rd, 32'h12345678);

        txn(0, 0, T_B, 32'h13, 32'h0, "p2_lb", rd, er);
        check("p2_lb_const", rd, 32'h00000012);
        txn(0, 0, T_BU, 32'h11, 32'h0, "p2_lbu", rd, er);
        check("p2_lbu_const", rd, 32'h00000056);
        txn(0, 0, T_H, 32'h12, 32'h0, "p2_lh", rd, er);
        check("p2_lh_const", rd, 32'h00001234);
        txn(0, 1, T_B, 32'h11, 32'h000000AB, "p2_sb", rd, er);
        txn(0, 0, T_W, 32'h10, 32'h0, "p2_lw", rd, er);
        check("p2_lw_const", rd, 32'h1234AB78);

        txn(0, 1, T_W, 32'h20, 32'hAABBCCDD, "p3_sw", rd, er);
        txn(0, 0, T_L, 32'h21, 32'h11223344, "p3_lwl", rd, er);
        check("p3_lwl_const", rd, 32'hCCDD3344);
        txn(0, 0, T_R, 32'h22, 32'h11223344, "p3_lwr", rd, er);
        check("p3_lwr_const", rd, 32'h1122AABB);
        txn(0, 1, T_L, 32'h21, 32'h11223344, "p3_swl", rd, er);
        txn(0, 0, T_W, 32'h20, 32'h0, "p3_lw1", rd, er);
        check("p3_swl_const", rd, 32'hAABB1122);
        txn(0, 1, T_W, 32'h20, 32'hAABBCCDD, "p3_sw2", rd, er);
        txn(0, 1, T_R, 32'h22, 32'h11223344, "p3_swr", rd, er);
        txn(0, 0, T_W, 32'h20, 32'h0, "p3_lw2", rd, er);
        check("p3_swr_const", rd, 32'h3344CCDD);

        txn(0, 0, T_W, 32'h12, 32'h0, "p4_lw_mis", rd, er);
        check("p4_lw_mis_err", 32'(er), 32'd1);
        txn(0, 1, T_H, 32'h13, 32'hFFFFFFFF, "p4_sh_mis", rd, er);
        check("p4_sh_mis_err", 32'(er), 32'd1);
        txn(0, 0, T_W, 32'h10, 32'h0, "p4_lw", rd, er);
        check("p4_unchanged", rd, 32'h1234AB78);

        // Reset during the WAIT cycle of a store: request is dropped
        drive(0, 1'b1, 1'b1, T_W, 32'h10, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("p5_ready", 32'(a_req_ready), 32'd1);
        begin
            bit any_resp;
            any_resp = 0;
            if (a_resp_valid) any_resp = 1;
            repeat (5) begin
                @(negedge clk);
                if (a_resp_valid) any_resp = 1;
            end
            check("p5_no_resp", 32'(any_resp), 32'd0);
        end
        txn(0, 0, T_W, 32'h10, 32'h0, "p5_lw", rd, er);
        check("p5_old_value", rd, 32'h1234AB78);

        // LATENCY=0 with valid held high: one response every other cycle
        model_access(1, 1'b1, T_W, 32'h1010, 32'hCAFEF00D, rd, er);
        drive(1, 1'b1, 1'b1, T_W, 32'h1010, 32'hCAFEF00D);
        pattern = 8'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pattern[i] = b_resp_valid;
        end
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("p6_pattern", 32'(pattern), 32'h55);
        @(negedge clk);
        txn(1, 0, T_W, 32'h010, 32'h0, "p6_alias", rd, er);
        check("p6_alias_const", rd, 32'hCAFEF00D);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] addr;
            addr = ($urandom & 32'hFFFF_F000) | $urandom_range(0, 63);
            txn(0, 1'($urandom), tys[$urandom_range(0, 6)], addr, $urandom, "rnd_a", rd, er);
        end
        for (int k = 0; k < 50; k++) begin
            logic [31:0] addr;
            addr = ($urandom & 32'hFFFF_F000) | $urandom_range(0, 31);
            txn(1, 1'($urandom), tys[$urandom_range(0, 6)], addr, $urandom, "rnd_b", rd, er);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
